// File: rtl/period_gen_p16_pkg.sv
// Shared constants, types and the period clamp for the 16-sample-per-clock square-wave generator.
package period_gen_p16_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned MIN_PERIOD = 32;

  typedef logic [31:0] period_t;

  // Periods shorter than two words could need two toggles in one word.
  function automatic period_t clamp_period(period_t p);
    return (p < period_t'(MIN_PERIOD)) ? period_t'(MIN_PERIOD) : p;
  endfunction

endpackage

// File: rtl/period_gen_p16_toggle_mask.sv
// Builds one 16-sample word with a single toggle at bit index remain_i:
// bits below remain_i carry level_i, bits at and above it carry ~level_i.
module toggle_mask_p16
  import period_gen_p16_pkg::*;
(
  input  logic              level_i,
  input  logic [3:0]        remain_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      word_o[i] = (i < 32'(remain_i)) ? level_i : ~level_i;
    end
  end

endmodule

// File: rtl/period_gen_p16.sv
// Square-wave generator emitting 16 samples per clock with glitch-free period updates at rising edges.
// Optional PERIOD_GEN_P16_SYNC_EN adds rise_strobe / rise_t marking the rising edge in each word.
module period_gen_p16
  import period_gen_p16_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] period_in,
  input  logic        period_load,
  output logic [15:0] out_p16,
  output logic [31:0] period_active,
  output logic        update_pending
`ifdef PERIOD_GEN_P16_SYNC_EN
  ,
  output logic        rise_strobe,
  output logic [3:0]  rise_t
`endif
);

  logic              level_q, level_d;
  period_t           remain_q, remain_d;
  period_t           active_q, active_d;
  period_t           pending_q, pending_d;
  logic              pend_q, pend_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic [WORD_W-1:0] mask;
  logic              toggle, rising;
  period_t           next_period, half;

  toggle_mask_p16 u_mask (
    .level_i  (level_q),
    .remain_i (remain_q[3:0]),
    .word_o   (mask)
  );

  assign toggle = (remain_q < period_t'(WORD_W));
  assign rising = toggle & ~level_q;

  always_comb begin
    level_d     = level_q;
    remain_d    = remain_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_d      = pend_q;
    out_d       = '0;
    next_period = active_q;
    half        = '0;
    if (!enable) begin
      // Idle: park at level 0 so the first enabled word rises at bit 0.
      level_d  = 1'b0;
      remain_d = '0;
      pend_d   = 1'b0;
      if (period_load) begin
        active_d  = clamp_period(period_in);
        pending_d = clamp_period(period_in);
      end else if (pend_q) begin
        active_d = pending_q;
      end
    end else begin
      out_d = toggle ? mask : {WORD_W{level_q}};
      if (toggle) begin
        if (rising && pend_q) begin
          next_period = pending_q;
          active_d    = pending_q;
          pend_d      = 1'b0;
        end
        half     = rising ? (next_period >> 1) : (next_period - (next_period >> 1));
        level_d  = ~level_q;
        remain_d = half - period_t'(WORD_W) + remain_q;
      end else begin
        remain_d = remain_q - period_t'(WORD_W);
      end
      // A load in the rising-toggle cycle lands after the old pending value was consumed.
      if (period_load) begin
        pending_d = clamp_period(period_in);
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q   <= 1'b0;
      remain_q  <= '0;
      active_q  <= period_t'(MIN_PERIOD);
      pending_q <= period_t'(MIN_PERIOD);
      pend_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      level_q   <= level_d;
      remain_q  <= remain_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
    end
  end

  assign out_p16        = out_q;
  assign period_active  = active_q;
  assign update_pending = pend_q;

`ifdef PERIOD_GEN_P16_SYNC_EN
  logic       rise_q;
  logic [3:0] rise_t_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rise_q   <= 1'b0;
      rise_t_q <= '0;
    end else begin
      rise_q   <= enable & rising;
      rise_t_q <= (enable & rising) ? remain_q[3:0] : 4'd0;
    end
  end

  assign rise_strobe = rise_q;
  assign rise_t      = rise_t_q;
`endif

endmodule
